// File: rtl/draw_buffer_scanout.sv
// Drains the draw-buffer RAM one 32-bit word at a time and streams four LSB-first pixels per word as an Avalon-ST frame.
// Define SCANOUT_LOOP_EN to rescan frames back to back after a single start.
module draw_buffer_scanout #(
    parameter int WORDS      = 9600,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_read,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic              busy_r;
    logic              frame_done_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              rd_pend_r;

    logic [31:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  fifo_cnt_r;

    logic [31:0]       hold_r;
    logic [1:0]        byte_idx_r;
    logic              hold_valid_r;
    logic              hold_sop_r;
    logic              hold_eop_r;
    logic [ADDR_W-1:0] pop_idx_r;

    logic [CNT_W:0]    occupancy_s;
    logic              issue_s;
    logic              fifo_has_s;
    logic              word_avail_s;
    logic              beat_acc_s;
    logic              last_byte_s;
    logic              pop_s;
    logic              pop_mem_s;
    logic              push_s;
    logic [31:0]       pop_word_s;
    logic              eop_acc_s;
    logic              frame_restart_s;

    // Read credit and unpacker handshake decode; the holding register counts as one of the word slots.
    always_comb begin
        occupancy_s     = (CNT_W+1)'(fifo_cnt_r) + (CNT_W+1)'(hold_valid_r) + (CNT_W+1)'(rd_pend_r);
        issue_s         = (state_r == FETCH) && (occupancy_s < (CNT_W+1)'(FIFO_DEPTH));
        fifo_has_s      = (fifo_cnt_r != {CNT_W{1'b0}});
        word_avail_s    = fifo_has_s || rd_pend_r;
        beat_acc_s      = hold_valid_r && st_ready;
        last_byte_s     = (byte_idx_r == 2'd3);
        pop_s           = (!hold_valid_r || (beat_acc_s && last_byte_s)) && word_avail_s;
        pop_mem_s       = pop_s && fifo_has_s;
        push_s          = rd_pend_r && !(pop_s && !fifo_has_s);
        pop_word_s      = fifo_has_s ? fifo_mem_r[rd_ptr_r] : m_readdata;
        eop_acc_s       = beat_acc_s && last_byte_s && hold_eop_r;
        frame_restart_s = ((state_r == IDLE) && start) || eop_acc_s;
    end

    assign m_chipselect = issue_s;
    assign m_read       = issue_s;
    assign m_address    = issue_s ? rd_addr_r : {ADDR_W{1'b0}};
    assign m_byteenable = 4'hF;
    assign st_data      = hold_r[7:0];
    assign st_valid     = hold_valid_r;
    assign st_sop       = hold_valid_r && hold_sop_r && (byte_idx_r == 2'd0);
    assign st_eop       = hold_valid_r && hold_eop_r && last_byte_s;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;

    // Frame sequencer: start acceptance, read address generation and end-of-frame handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            rd_addr_r    <= {ADDR_W{1'b0}};
            rd_pend_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            rd_pend_r    <= issue_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= FETCH;
                        busy_r    <= 1'b1;
                        rd_addr_r <= {ADDR_W{1'b0}};
                    end
                end
                FETCH: begin
                    if (issue_s) begin
                        if (rd_addr_r == LAST_ADDR) begin
                            state_r <= DRAIN;
                        end else begin
                            rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DRAIN: begin
                    if (eop_acc_s) begin
                        frame_done_r <= 1'b1;
`ifdef SCANOUT_LOOP_EN
                        state_r      <= FETCH;
                        rd_addr_r    <= {ADDR_W{1'b0}};
`else
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Word FIFO pointers and occupancy; a word popped while the FIFO is empty bypasses storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_mem_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_mem_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   fifo_cnt_r <= fifo_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Word FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= m_readdata;
        end
    end

    // Unpacker: holds one word and shifts out its bytes LSB first, tagging frame boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r       <= 32'h0000_0000;
            byte_idx_r   <= 2'd0;
            hold_valid_r <= 1'b0;
            hold_sop_r   <= 1'b0;
            hold_eop_r   <= 1'b0;
            pop_idx_r    <= {ADDR_W{1'b0}};
        end else begin
            if (pop_s) begin
                hold_r       <= pop_word_s;
                byte_idx_r   <= 2'd0;
                hold_valid_r <= 1'b1;
                hold_sop_r   <= (pop_idx_r == {ADDR_W{1'b0}});
                hold_eop_r   <= (pop_idx_r == LAST_ADDR);
            end else if (beat_acc_s) begin
                hold_r       <= {8'h00, hold_r[31:8]};
                byte_idx_r   <= byte_idx_r + 2'd1;
                hold_valid_r <= !last_byte_s;
            end
            if (frame_restart_s) begin
                pop_idx_r <= {ADDR_W{1'b0}};
            end else if (pop_s && (pop_idx_r != LAST_ADDR)) begin
                pop_idx_r <= pop_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_draw_buffer_scanout.sv
// Self-checking bench for draw_buffer_scanout: RAM model, per-cycle compare against a frame-level reference model.
module tb_draw_buffer_scanout;

    localparam int WORDS      = 4;
    localparam int ADDR_W     = 14;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              st_ready = 1'b1;
    logic              busy, frame_done, m_chipselect, m_read;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_readdata;
    logic [7:0]        st_data;
    logic              st_valid, st_sop, st_eop;

    draw_buffer_scanout #(.WORDS(WORDS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_read(m_read),
        .m_byteenable(m_byteenable), .m_readdata(m_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM second port: data one cycle after the address, garbage otherwise
    logic [31:0] ram [WORDS];
    always @(posedge clk) m_readdata <= (m_read === 1'b1) ? ram[int'(m_address) % WORDS] : $urandom;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected beat stream for the frame plus handshake bookkeeping
    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       lw;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      bt_c;
    logic [7:0] acc_q[$];
    bit         m_busy = 0, m_fd = 0, busy_n, fd_n;
    int         rd_issued = 0, words_done = 0;
    int         beat_cnt = 0, fd_cnt = 0, first_rd_cyc = -1, first_val_cyc = -1, fd_cyc = -1;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic void build_frame();
        beat_t b;
        exp_q.delete();
        for (int w = 0; w < WORDS; w++) begin
            for (int k = 0; k < 4; k++) begin
                b.d   = ram[w][8*k +: 8];
                b.sop = (w == 0 && k == 0);
                b.eop = (w == WORDS - 1 && k == 3);
                b.lw  = (k == 3);
                exp_q.push_back(b);
            end
        end
        rd_issued  = 0;
        words_done = 0;
    endfunction

    // Compare process: checks DUT against the model every cycle, then advances the model
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_busy = 0; m_fd = 0; rd_issued = 0; words_done = 0; prev_valid = 1'b0;
        end else begin
            busy_n = m_busy;
            fd_n   = 0;
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (!m_busy) chk("idle_quiet", {30'd0, m_read, st_valid}, 32'd0);
            if (m_read) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                chk("rd_cs", {31'd0, m_chipselect}, 32'd1);
                chk("rd_be", {28'd0, m_byteenable}, 32'hF);
                chk("rd_addr", {18'd0, m_address}, 32'(rd_issued));
                chk("rd_credit", 32'(rd_issued - words_done), 32'(rd_issued - words_done < FIFO_DEPTH ? rd_issued - words_done : FIFO_DEPTH - 1));
                rd_issued++;
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", {31'd0, st_valid}, 32'd1);
                chk("stall_data", {24'd0, st_data}, {24'd0, prev_data});
            end
            if (st_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {31'd0, st_valid}, 32'd0);
                end else begin
                    bt_c = exp_q.pop_front();
                    chk("st_data", {24'd0, st_data}, {24'd0, bt_c.d});
                    chk("st_sop", {31'd0, st_sop}, {31'd0, bt_c.sop});
                    chk("st_eop", {31'd0, st_eop}, {31'd0, bt_c.eop});
                    beat_cnt++;
                    acc_q.push_back(st_data);
                    if (bt_c.lw) words_done++;
                    if (bt_c.eop) begin
                        fd_n = 1;
`ifdef SCANOUT_LOOP_EN
                        build_frame();
`else
                        busy_n = 0;
`endif
                    end
                end
            end
            if (start && !m_busy) begin
                busy_n = 1;
                build_frame();
            end
            prev_valid = st_valid;
            prev_ready = st_ready;
            prev_data  = st_data;
            m_busy = busy_n;
            m_fd   = fd_n;
        end
    end

    // Sink ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled
    int ready_mode = 0;
    int rcnt = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       st_ready = 1'b1;
            1:       st_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            2:       st_ready = ($urandom_range(0, 3) != 0);
            default: st_ready = 1'b0;
        endcase
        rcnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_stats();
        beat_cnt = 0; fd_cnt = 0; acc_q.delete();
        first_rd_cyc = -1; first_val_cyc = -1; fd_cyc = -1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {3'd0, busy, frame_done, m_chipselect, m_read, st_valid, st_sop, st_eop, st_data, m_address}, 32'd0);
        chk({name, "_be"}, {28'd0, m_byteenable}, 32'hF);
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0;

    initial begin
        ram[0] = 32'h03020100; ram[1] = 32'h07060504; ram[2] = 32'h0B0A0908; ram[3] = 32'h0F0E0D0C;
        repeat (3) tick();
        check_outputs_zero("reset_state");
        reset = 1'b0;
        tick();

`ifdef SCANOUT_LOOP_EN
        ready_mode = 1;
        reset_stats();
        pulse_start();
        for (int n = 0; n < 2000 && fd_cnt < 3; n++) tick();
        chk("loop_frames", 32'(fd_cnt), 32'(fd_cnt >= 3 ? fd_cnt : 3));
        chk("loop_busy", {31'd0, busy}, 32'd1);
        if (acc_q.size() > 16) chk("loop_second_first", {24'd0, acc_q[16]}, 32'h00);
        reset = 1'b1;
        #1;
        check_outputs_zero("loop_reset");
        tick();
        reset = 1'b0;
        tick();
`else
        // Basic frame with literal timing and data
        reset_stats();
        t0 = cyc;
        pulse_start();
        wait_idle(200, "basic_timeout");
        chk("basic_first_read", 32'(first_rd_cyc), 32'(t0 + 1));
        chk("basic_first_valid", 32'(first_val_cyc), 32'(t0 + 3));
        chk("basic_done_cycle", 32'(fd_cyc), 32'(t0 + 19));
        chk("basic_done_count", 32'(fd_cnt), 32'd1);
        chk("basic_beats", 32'(beat_cnt), 32'd16);
        for (int i = 0; i < acc_q.size(); i++) chk("basic_byte", {24'd0, acc_q[i]}, 32'(i));

        // Backpressure 1,0,0,1
        ready_mode = 1;
        reset_stats();
        pulse_start();
        wait_idle(400, "bp_timeout");
        ready_mode = 0;
        chk("bp_beats", 32'(beat_cnt), 32'd16);
        for (int i = 0; i < acc_q.size(); i++) chk("bp_byte", {24'd0, acc_q[i]}, 32'(i));

        // Long stall: credit limit caps reads at FIFO_DEPTH
        ready_mode = 3;
        tick();
        reset_stats();
        pulse_start();
        repeat (50) tick();
        chk("stall_reads", 32'(rd_issued), 32'(FIFO_DEPTH));
        chk("stall_no_beats", 32'(beat_cnt), 32'd0);
        ready_mode = 0;
        wait_idle(200, "stall_timeout");
        chk("stall_beats", 32'(beat_cnt), 32'd16);

        // Starts while busy are ignored
        reset_stats();
        pulse_start();
        repeat (4) tick();
        pulse_start();
        repeat (4) tick();
        pulse_start();
        wait_idle(200, "dstart_timeout");
        repeat (5) tick();
        chk("dstart_done_count", 32'(fd_cnt), 32'd1);
        chk("dstart_beats", 32'(beat_cnt), 32'd16);

        // Asynchronous reset mid-frame, then a clean frame
        randomize_ram();
        pulse_start();
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        tick();
        reset = 1'b0;
        tick();
        reset_stats();
        pulse_start();
        wait_idle(200, "postrst_timeout");
        chk("postrst_beats", 32'(beat_cnt), 32'd16);
        if (acc_q.size() > 0) chk("postrst_first", {24'd0, acc_q[0]}, {24'd0, ram[0][7:0]});

        // Randomized frames with random backpressure and stray starts
        for (int f = 0; f < 6; f++) begin
            randomize_ram();
            ready_mode = 2;
            reset_stats();
            pulse_start();
            repeat (10) begin
                start = ($urandom_range(0, 7) == 0);
                tick();
            end
            start = 1'b0;
            wait_idle(400, "rand_timeout");
            chk("rand_beats", 32'(beat_cnt), 32'd16);
            chk("rand_done_count", 32'(fd_cnt), 32'd1);
        end
        ready_mode = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
